// File: rtl/line_readout_scheduler.sv
// Streams selected lines of a frame out of a line buffer as a valid/ready pixel stream.
// One pixel per 3 cycles at best (address, registered read, send); OUT_READY low holds the pixel in place.
module line_readout_scheduler #(
  parameter int H = 752,
  parameter int V = 480,
  localparam int AW = $clog2(H),
  localparam int LW = $clog2(V)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [LW-1:0] FIRST_LINE,
  input  logic [LW-1:0] LINE_STEP,
  input  logic          LINE_READY,
  input  logic [7:0]    BUF_DATA,
  output logic [LW-1:0] INTERESTING_LINE,
  output logic [AW-1:0] READ_ADDRESS,
  output logic          RESET_READY_FLAG,
  output logic [7:0]    OUT_DATA,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic          OUT_LAST,
  output logic [LW-1:0] OUT_LINE,
  output logic          BUSY,
  output logic          DONE
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_ADDR    = 3'd2;
  localparam logic [2:0] S_LATCH   = 3'd3;
  localparam logic [2:0] S_SEND    = 3'd4;
  localparam logic [2:0] S_RELEASE = 3'd5;

  localparam logic [LW:0]   LAST_LINE = (LW+1)'(V - 1);
  localparam logic [AW-1:0] LAST_COL  = AW'(H - 1);

  logic [2:0]    state;
  logic [LW-1:0] line_step;
  logic [LW:0]   next_line;
  logic          first_ok;
  logic          at_last;

  // One extra bit so the line advance past the frame end cannot wrap back in range.
  assign next_line        = {1'b0, OUT_LINE} + {1'b0, line_step};
  assign first_ok         = {1'b0, FIRST_LINE} <= LAST_LINE;
  assign at_last          = READ_ADDRESS == LAST_COL;
  assign BUSY             = state != S_IDLE;
  assign RESET_READY_FLAG = state == S_RELEASE;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state            <= S_IDLE;
      line_step        <= LW'(1);
      INTERESTING_LINE <= '1;
      READ_ADDRESS     <= '0;
      OUT_DATA         <= '0;
      OUT_VALID        <= 1'b0;
      OUT_LAST         <= 1'b0;
      OUT_LINE         <= '0;
      DONE             <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          INTERESTING_LINE <= '1;
          if (START) begin
            line_step <= (LINE_STEP == '0) ? LW'(1) : LINE_STEP;
            if (first_ok) begin
              INTERESTING_LINE <= FIRST_LINE;
              OUT_LINE         <= FIRST_LINE;
              READ_ADDRESS     <= '0;
              state            <= S_WAIT;
            end else begin
              DONE <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (LINE_READY) state <= S_ADDR;
        end
        // Address is held here for the buffer's registered read.
        S_ADDR: state <= S_LATCH;
        S_LATCH: begin
          OUT_DATA  <= BUF_DATA;
          OUT_VALID <= 1'b1;
          OUT_LAST  <= at_last;
          state     <= S_SEND;
        end
        S_SEND: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            if (at_last) begin
              state <= S_RELEASE;
            end else begin
              READ_ADDRESS <= READ_ADDRESS + AW'(1);
              state        <= S_ADDR;
            end
          end
        end
        S_RELEASE: begin
          READ_ADDRESS <= '0;
          if (next_line <= LAST_LINE) begin
            INTERESTING_LINE <= next_line[LW-1:0];
            OUT_LINE         <= next_line[LW-1:0];
            state            <= S_WAIT;
          end else begin
            INTERESTING_LINE <= '1;
            DONE             <= 1'b1;
            state            <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_readout_scheduler.sv
// Bench for line_readout_scheduler: table of scans checked through a pixel scoreboard plus corner sequences.
module tb_line_readout_scheduler;
  localparam int H = 4;
  localparam int V = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] first_line = '0;
  logic [2:0] line_step = '0;
  logic       line_ready = 1'b0;
  logic [7:0] buf_data = '0;
  logic       out_ready = 1'b1;
  logic [2:0] interesting_line;
  logic [1:0] read_address;
  logic       reset_ready_flag;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic [2:0] out_line;
  logic       busy;
  logic       done;

  // Second instance with a wider line field so an out-of-frame FIRST_LINE is representable.
  logic       start_b = 1'b0;
  logic [3:0] first_line_b = '0;
  logic [3:0] line_step_b = '0;
  logic       line_ready_b = 1'b0;
  logic [7:0] buf_data_b = '0;
  logic       out_ready_b = 1'b1;
  logic [3:0] interesting_line_b;
  logic [1:0] read_address_b;
  logic       reset_ready_flag_b;
  logic [7:0] out_data_b;
  logic       out_valid_b;
  logic       out_last_b;
  logic [3:0] out_line_b;
  logic       busy_b;
  logic       done_b;

  always #5 clk = ~clk;

  line_readout_scheduler #(.H(H), .V(V)) dut (
    .CLK(clk), .RST(rst), .START(start), .FIRST_LINE(first_line), .LINE_STEP(line_step),
    .LINE_READY(line_ready), .BUF_DATA(buf_data), .INTERESTING_LINE(interesting_line),
    .READ_ADDRESS(read_address), .RESET_READY_FLAG(reset_ready_flag), .OUT_DATA(out_data),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_LAST(out_last), .OUT_LINE(out_line),
    .BUSY(busy), .DONE(done)
  );

  line_readout_scheduler #(.H(4), .V(9)) dut_b (
    .CLK(clk), .RST(rst), .START(start_b), .FIRST_LINE(first_line_b), .LINE_STEP(line_step_b),
    .LINE_READY(line_ready_b), .BUF_DATA(buf_data_b), .INTERESTING_LINE(interesting_line_b),
    .READ_ADDRESS(read_address_b), .RESET_READY_FLAG(reset_ready_flag_b), .OUT_DATA(out_data_b),
    .OUT_VALID(out_valid_b), .OUT_READY(out_ready_b), .OUT_LAST(out_last_b), .OUT_LINE(out_line_b),
    .BUSY(busy_b), .DONE(done_b)
  );

  int n_vec = 0;
  int n_err = 0;
  int rrf_cnt = 0;
  int done_cnt = 0;
  int rdy_delay = 2;
  int bp_mode = 0;
  logic manual_ready = 1'b1;
  logic [2:0] last_line = '0;
  logic [13:0] sb[$];

  typedef struct {
    logic [2:0] first;
    logic [2:0] step;
    int         mode;
    bit         glitch;
    int         exp_nl;
    logic [2:0] exp_last;
  } vec_t;
  vec_t tbl[6];

  function automatic logic [7:0] pix(input logic [2:0] l, input logic [1:0] c);
    return {l, 3'b101, c};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Line buffer, ready flag and consumer model.
  initial begin
    logic [2:0] s_il;
    logic [1:0] s_addr;
    logic s_rrf, s_busy;
    int rdy_cnt;
    rdy_cnt = 0;
    forever begin
      @(negedge clk);
      s_il = interesting_line; s_addr = read_address; s_rrf = reset_ready_flag; s_busy = busy;
      @(posedge clk); #1;
      buf_data = pix(s_il, s_addr);
      if (rst || s_rrf) begin
        line_ready = 1'b0; rdy_cnt = 0;
      end else if (s_busy && !line_ready) begin
        if (rdy_cnt >= rdy_delay) line_ready = 1'b1;
        else rdy_cnt++;
      end
      case (bp_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        2: out_ready = manual_ready;
        default: out_ready = (read_address != 2'd2);
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (reset_ready_flag) rrf_cnt++;
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        last_line = out_line;
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL sb_extra: got line %0d col %0d data %h, expected no pixel", out_line, read_address, out_data);
        end else begin
          check("pixel{line,col,last,data}", 32'({out_line, read_address, out_last, out_data}), 32'(sb.pop_front()));
        end
      end
    end
  end

  task automatic start_scan(input logic [2:0] f, input logic [2:0] s);
    int l, st;
    @(posedge clk); #1;
    first_line = f; line_step = s; start = 1'b1;
    rrf_cnt = 0; done_cnt = 0;
    rdy_delay = $urandom_range(0, 4);
    st = (s == 3'd0) ? 1 : int'(s);
    l = int'(f);
    while (l <= V - 1) begin
      for (int c = 0; c < H; c++) sb.push_back({3'(l), 2'(c), 1'(c == H - 1), pix(3'(l), 2'(c))});
      l += st;
    end
    @(posedge clk); #1;
    start = 1'b0;
    first_line = 3'($urandom); line_step = 3'($urandom);
  endtask

  task automatic wait_done(input int exp_nl, input logic [2:0] exp_last);
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      if (done_cnt > 0) break;
    end
    repeat (4) @(posedge clk);
    #1;
    check("done_count", 32'(done_cnt), 32'd1);
    check("release_count", 32'(rrf_cnt), 32'(exp_nl));
    check("sb_left", 32'(sb.size()), 32'd0);
    check("last_line", 32'(last_line), 32'(exp_last));
    check("idle{busy,il,valid}", 32'({busy, interesting_line, out_valid}), 32'({1'b0, 3'h7, 1'b0}));
    if (done_cnt == 0) begin
      rst = 1'b1; sb.delete();
      @(posedge clk); #1;
      rst = 1'b0;
    end
  endtask

  initial begin
    logic [12:0] snap_exp;
    logic act;
    bit seen;
    tbl[0] = '{3'd2, 3'd3, 0, 1'b0, 2, 3'd5};
    tbl[1] = '{3'd6, 3'd0, 0, 1'b0, 2, 3'd7};
    tbl[2] = '{3'd0, 3'd7, 1, 1'b0, 2, 3'd7};
    tbl[3] = '{3'd7, 3'd1, 0, 1'b0, 1, 3'd7};
    tbl[4] = '{3'd1, 3'd2, 1, 1'b0, 4, 3'd7};
    tbl[5] = '{3'd2, 3'd3, 0, 1'b1, 2, 3'd5};

    @(negedge clk);
    check("reset_state", 32'({interesting_line, read_address, out_data, out_line, out_valid, out_last,
                              reset_ready_flag, busy, done}), 32'({3'h7, 2'h0, 8'h0, 3'h0, 5'h0}));
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (tbl[k]) begin
      bp_mode = tbl[k].mode;
      start_scan(tbl[k].first, tbl[k].step);
      if (tbl[k].glitch) begin
        repeat (3) @(posedge clk);
        #1; first_line = 3'd0; line_step = 3'd1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
      end
      wait_done(tbl[k].exp_nl, tbl[k].exp_last);
    end

    // Consumer stalls on the first pixel of line 3 for ten cycles.
    bp_mode = 2; manual_ready = 1'b0;
    start_scan(3'd3, 3'd7);
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    snap_exp = {pix(3'd3, 2'd0), 1'b0, 1'b1, 2'd0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      check("stall_hold{data,last,valid,addr,done}", 32'({out_data, out_last, out_valid, read_address, done}), 32'(snap_exp));
      @(negedge clk);
    end
    manual_ready = 1'b1;
    wait_done(1, 3'd3);
    bp_mode = 0;

    // Out-of-frame first line on the V=9 instance, then the last legal line.
    @(posedge clk); #1;
    first_line_b = 4'd9; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    @(negedge clk);
    check("oob_start{busy,done,il}", 32'({busy_b, done_b, interesting_line_b}), 32'({1'b0, 1'b1, 4'hF}));
    @(negedge clk);
    check("oob_after{busy,done,il}", 32'({busy_b, done_b, interesting_line_b}), 32'({1'b0, 1'b0, 4'hF}));
    @(posedge clk); #1;
    first_line_b = 4'd8; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    @(negedge clk);
    check("edge_start{busy,done,il}", 32'({busy_b, done_b, interesting_line_b}), 32'({1'b1, 1'b0, 4'd8}));

    // Asynchronous reset while column 2 is held in SEND.
    bp_mode = 3;
    start_scan(3'd2, 3'd3);
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid && (read_address == 2'd2);
    end
    check("reached_col2", 32'(seen), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async_reset", 32'({interesting_line, read_address, out_data, out_line, out_valid, out_last,
                              reset_ready_flag, busy, done, busy_b}), 32'({3'h7, 2'h0, 8'h0, 3'h0, 6'h0}));
    sb.delete();
    bp_mode = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    act = 1'b0;
    repeat (6) begin
      @(negedge clk);
      act = act | out_valid | busy | reset_ready_flag | done;
    end
    check("quiet_after_reset", 32'(act), 32'd0);
    start_scan(3'd2, 3'd3);
    wait_done(2, 3'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
